// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame burst writer: FSM states, FIFO-clear
// duration, burst-length clamp and ring-index increment.
package frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_CLR,
    S_WAIT_DATA,
    S_BURST,
    S_DONE
  } state_t;

  localparam int CLR_CYCLES = 4;

  function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] ring_next(input logic [31:0] idx, input int n);
    if (idx >= 32'(n - 1)) return 32'd0;
    return idx + 32'd1;
  endfunction

endpackage

// File: rtl/frame_buf_sel.sv
// Next frame-buffer selection for the write ring. With FRAME_BUF_SKIP_EN defined
// the buffer held by the reader is stepped over; otherwise rd_idx is ignored.
module frame_buf_sel
  import frame_pkg::*;
#(
  parameter int NUM_BUFS     = 4,
  parameter int BUF_IDX_BITS = $clog2(NUM_BUFS)
) (
  input  logic [BUF_IDX_BITS-1:0] last_idx,
  input  logic [BUF_IDX_BITS-1:0] rd_idx,
  output logic [BUF_IDX_BITS-1:0] sel
);

  logic [BUF_IDX_BITS-1:0] cand;

  always_comb begin
    cand = BUF_IDX_BITS'(ring_next(32'(last_idx), NUM_BUFS));
`ifdef FRAME_BUF_SKIP_EN
    sel  = (cand == rd_idx) ? BUF_IDX_BITS'(ring_next(32'(cand), NUM_BUFS)) : cand;
`else
    sel  = cand;
`endif
  end

`ifndef FRAME_BUF_SKIP_EN
  logic rd_idx_unused;
  assign rd_idx_unused = ^rd_idx;
`endif

endmodule

// File: rtl/frame_burst_writer.sv
// Moves one frame from the write FIFO into a rotating ring of memory buffers as
// bounded bursts. Define FRAME_BUF_SKIP_EN to avoid the reader's current buffer.
module frame_burst_writer
  import frame_pkg::*;
#(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 25,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = 64,
  parameter int NUM_BUFS      = 4,
  parameter int BUF_IDX_BITS  = $clog2(NUM_BUFS)
) (
  input  logic                          mem_clk,
  input  logic                          rst,
  input  logic                          write_req,
  output logic                          write_req_ack,
  output logic                          write_finish,
  input  logic [ADDR_BITS-1:0]          write_len,
  input  logic [NUM_BUFS*ADDR_BITS-1:0] buf_base,
  input  logic [BUF_IDX_BITS-1:0]       rd_buf_index,
  output logic [BUF_IDX_BITS-1:0]       wr_buf_index,
  output logic [BUF_IDX_BITS-1:0]       last_buf_index,
  output logic                          fifo_aclr,
  input  logic [15:0]                   rdusedw,
  output logic                          wr_burst_req,
  output logic [BURST_BITS-1:0]         wr_burst_len,
  output logic [ADDR_BITS-1:0]          wr_burst_addr,
  input  logic                          wr_burst_data_req,
  input  logic                          wr_burst_finish
);

  localparam int CLR_W = $clog2(CLR_CYCLES);
  localparam logic [31:0] DATA_BITS_CHK = 32'(MEM_DATA_BITS);

  state_t                  state, state_nxt;
  logic [CLR_W-1:0]        clr_cnt, clr_cnt_nxt;
  logic [ADDR_BITS-1:0]    remaining, remaining_nxt;
  logic [ADDR_BITS-1:0]    offset, offset_nxt;
  logic                    ack_nxt, finish_nxt, aclr_nxt, req_nxt;
  logic [BURST_BITS-1:0]   len_nxt, blen;
  logic [ADDR_BITS-1:0]    addr_nxt, base_sel;
  logic [BUF_IDX_BITS-1:0] wr_idx_nxt, last_idx_nxt, sel;

  // The data strobe is only observed by the controller side; nothing here consumes it.
  logic unused_ok;
  assign unused_ok = wr_burst_data_req ^ DATA_BITS_CHK[0];

  frame_buf_sel #(
    .NUM_BUFS    (NUM_BUFS),
    .BUF_IDX_BITS(BUF_IDX_BITS)
  ) u_sel (
    .last_idx(last_buf_index),
    .rd_idx  (rd_buf_index),
    .sel     (sel)
  );

  assign blen     = BURST_BITS'(min_len(32'(remaining), 32'(BURST_SIZE)));
  assign base_sel = buf_base[wr_buf_index * ADDR_BITS +: ADDR_BITS];

  always_comb begin
    state_nxt     = state;
    clr_cnt_nxt   = clr_cnt;
    remaining_nxt = remaining;
    offset_nxt    = offset;
    ack_nxt       = 1'b0;
    finish_nxt    = 1'b0;
    aclr_nxt      = 1'b0;
    req_nxt       = 1'b0;
    len_nxt       = wr_burst_len;
    addr_nxt      = wr_burst_addr;
    wr_idx_nxt    = wr_buf_index;
    last_idx_nxt  = last_buf_index;
    case (state)
      S_IDLE: begin
        if (write_req) begin
          state_nxt = S_ACK;
          ack_nxt   = 1'b1;
        end
      end
      S_ACK: begin
        remaining_nxt = write_len;
        offset_nxt    = '0;
        wr_idx_nxt    = sel;
        clr_cnt_nxt   = '0;
        aclr_nxt      = 1'b1;
        state_nxt     = S_CLR;
      end
      S_CLR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
          // A zero-length frame completes without touching memory or last_buf_index.
          if (remaining == '0) begin
            state_nxt  = S_DONE;
            finish_nxt = 1'b1;
          end else begin
            state_nxt  = S_WAIT_DATA;
          end
        end else begin
          aclr_nxt = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (32'(rdusedw) >= 32'(blen)) begin
          state_nxt = S_BURST;
          req_nxt   = 1'b1;
          len_nxt   = blen;
          addr_nxt  = base_sel + offset;
        end
      end
      S_BURST: begin
        if (wr_burst_finish) begin
          offset_nxt    = offset + ADDR_BITS'(wr_burst_len);
          remaining_nxt = remaining - ADDR_BITS'(wr_burst_len);
          if (remaining == ADDR_BITS'(wr_burst_len)) begin
            state_nxt    = S_DONE;
            finish_nxt   = 1'b1;
            last_idx_nxt = wr_buf_index;
          end else begin
            state_nxt    = S_WAIT_DATA;
          end
        end else begin
          req_nxt = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state          <= S_IDLE;
      clr_cnt        <= '0;
      remaining      <= '0;
      offset         <= '0;
      write_req_ack  <= 1'b0;
      write_finish   <= 1'b0;
      fifo_aclr      <= 1'b0;
      wr_burst_req   <= 1'b0;
      wr_burst_len   <= '0;
      wr_burst_addr  <= '0;
      wr_buf_index   <= BUF_IDX_BITS'(NUM_BUFS - 1);
      last_buf_index <= BUF_IDX_BITS'(NUM_BUFS - 1);
    end else begin
      state          <= state_nxt;
      clr_cnt        <= clr_cnt_nxt;
      remaining      <= remaining_nxt;
      offset         <= offset_nxt;
      write_req_ack  <= ack_nxt;
      write_finish   <= finish_nxt;
      fifo_aclr      <= aclr_nxt;
      wr_burst_req   <= req_nxt;
      wr_burst_len   <= len_nxt;
      wr_burst_addr  <= addr_nxt;
      wr_buf_index   <= wr_idx_nxt;
      last_buf_index <= last_idx_nxt;
    end
  end

endmodule

// File: tb/tb_frame_burst_writer.sv
// Self-checking bench for frame_burst_writer: frame table, hand-built corner
// sequences and randomized frames against a burst-list/ring model.
module tb_frame_burst_writer;

  localparam int AW = 25;
  localparam int BW = 10;
  localparam int BS = 64;
  localparam int NB = 4;
  localparam int IW = 2;

  logic             mem_clk = 1'b0;
  logic             rst = 1'b1;
  logic             write_req = 1'b0;
  logic             write_req_ack, write_finish;
  logic [AW-1:0]    write_len = '0;
  logic [NB*AW-1:0] buf_base;
  logic [IW-1:0]    rd_buf_index = IW'(NB - 1);
  logic [IW-1:0]    wr_buf_index, last_buf_index;
  logic             fifo_aclr;
  logic [15:0]      rdusedw = 16'd512;
  logic             wr_burst_req;
  logic [BW-1:0]    wr_burst_len;
  logic [AW-1:0]    wr_burst_addr;
  logic             wr_burst_data_req = 1'b0;
  logic             wr_burst_finish = 1'b0;

  always #5 mem_clk = ~mem_clk;

  frame_burst_writer #(
    .MEM_DATA_BITS(64), .ADDR_BITS(AW), .BURST_BITS(BW), .BURST_SIZE(BS), .NUM_BUFS(NB)
  ) dut (
    .mem_clk(mem_clk), .rst(rst), .write_req(write_req), .write_req_ack(write_req_ack),
    .write_finish(write_finish), .write_len(write_len), .buf_base(buf_base),
    .rd_buf_index(rd_buf_index), .wr_buf_index(wr_buf_index), .last_buf_index(last_buf_index),
    .fifo_aclr(fifo_aclr), .rdusedw(rdusedw), .wr_burst_req(wr_burst_req),
    .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish)
  );

  typedef struct {
    int len;
    int nb;
    int last_len;
    int buf_i;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  int            m_last;
  logic [AW-1:0] bases [NB];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_next(input int last);
    int c;
    c = (last + 1) % NB;
`ifdef FRAME_BUF_SKIP_EN
    if (c == int'(rd_buf_index)) c = (c + 1) % NB;
`endif
    return c;
  endfunction

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, write_req_ack, 0);
    check({tag, "_finish"}, write_finish, 0);
    check({tag, "_aclr"}, fifo_aclr, 0);
    check({tag, "_req"}, wr_burst_req, 0);
    check({tag, "_len"}, wr_burst_len, 0);
    check({tag, "_addr"}, wr_burst_addr, 0);
    check({tag, "_wr_idx"}, wr_buf_index, NB - 1);
    check({tag, "_last_idx"}, last_buf_index, NB - 1);
  endtask

  // One frame from request to completion; returns the bursts the DUT issued.
  task automatic run_frame(input int len, input bit starve, output int nb, output int last_len);
    int eb, off, rem, blen, t, d;
    eb = model_next(m_last);
    nb = 0;
    last_len = 0;
    if (!starve) rdusedw = 16'd512;
    write_len = AW'(len);
    write_req = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!write_req_ack && t < 20);
    write_req = 1'b0;
    check("ack_latency", t, 1);
    tick();
    check("ack_pulse", write_req_ack, 0);
    check("aclr_first", fifo_aclr, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("aclr_hold", fifo_aclr, 1);
    end
    tick();
    check("aclr_end", fifo_aclr, 0);
    check("wr_buf_index", wr_buf_index, eb);
    if (len == 0) begin
      check("zero_finish", write_finish, 1);
      check("zero_noburst", wr_burst_req, 0);
    end
    rem = len;
    off = 0;
    while (rem > 0) begin
      blen = (rem < BS) ? rem : BS;
      if (starve) begin
        rdusedw = 16'($urandom_range(0, blen - 1));
        d = $urandom_range(1, 4);
        for (int i = 0; i < d; i++) begin
          wr_burst_finish = 1'($urandom_range(0, 1));
          tick();
          check("starve_noreq", wr_burst_req, 0);
        end
        wr_burst_finish = 1'b0;
        rdusedw = 16'(blen + $urandom_range(0, 50));
      end
      t = 0;
      do begin tick(); t++; end while (!wr_burst_req && t < 40);
      check("req_latency", t, 1);
      check("burst_len", wr_burst_len, blen);
      check("burst_addr", wr_burst_addr, AW'(bases[eb] + AW'(off)));
      nb++;
      last_len = int'(wr_burst_len);
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        wr_burst_data_req = 1'($urandom_range(0, 1));
        tick();
        check("req_hold", wr_burst_req, 1);
      end
      wr_burst_data_req = 1'b0;
      wr_burst_finish = 1'b1;
      tick();
      wr_burst_finish = 1'b0;
      check("req_drop", wr_burst_req, 0);
      rem -= blen;
      off += blen;
      check("write_finish", write_finish, (rem == 0));
    end
    if (len > 0) m_last = eb;
    check("last_buf_index", last_buf_index, m_last);
    tick();
    check("finish_pulse", write_finish, 0);
  endtask

  initial begin
    vec_t tbl [5];
    int nb, ll, t, len;

    bases[0] = 25'h0100000;
    bases[1] = 25'h0200000;
    bases[2] = 25'h0300000;
    bases[3] = 25'h1FFFFF0;
    for (int i = 0; i < NB; i++) buf_base[i*AW +: AW] = bases[i];

    tbl[0] = '{200, 4, 8, 0};
    tbl[1] = '{64, 1, 64, 1};
    tbl[2] = '{65, 2, 1, 2};
    tbl[3] = '{1, 1, 1, 3};
    tbl[4] = '{128, 2, 64, 0};

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    m_last = NB - 1;

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].len, 1'b0, nb, ll);
      check("tbl_nbursts", nb, tbl[i].nb);
      check("tbl_last_len", ll, tbl[i].last_len);
`ifndef FRAME_BUF_SKIP_EN
      check("tbl_buf", wr_buf_index, tbl[i].buf_i);
`endif
    end

    // FIFO starved at 63 words for a 64-word burst.
    write_len = AW'(64);
    rdusedw = 16'd63;
    write_req = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!write_req_ack && t < 20);
    write_req = 1'b0;
    check("starve_ack", write_req_ack, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("starve63_noreq", wr_burst_req, 0);
    end
    rdusedw = 16'd64;
    tick();
    check("starve64_req", wr_burst_req, 1);
    check("starve64_len", wr_burst_len, 64);
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
    check("starve_finish", write_finish, 1);
    m_last = model_next(m_last);
    check("starve_last", last_buf_index, m_last);
    tick();

    // Zero-length frame.
    run_frame(0, 1'b0, nb, ll);
    check("zero_nbursts", nb, 0);

    // Reset in the middle of a burst.
    write_len = AW'(100);
    rdusedw = 16'd512;
    write_req = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!write_req_ack && t < 20);
    write_req = 1'b0;
    t = 0;
    do begin tick(); t++; end while (!wr_burst_req && t < 20);
    check("midrst_req_seen", wr_burst_req, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    m_last = NB - 1;
    run_frame(100, 1'b0, nb, ll);
    check("midrst_buf0", wr_buf_index, 0);
    check("midrst_nbursts", nb, 2);

`ifdef FRAME_BUF_SKIP_EN
    for (int i = 0; i < NB && m_last != 0; i++) run_frame(8, 1'b0, nb, ll);
    rd_buf_index = 2'd1;
    run_frame(10, 1'b0, nb, ll);
    check("skip_buf", wr_buf_index, 2);
`endif

    for (int i = 0; i < 25; i++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 300));
      rd_buf_index = IW'($urandom_range(0, NB - 1));
      run_frame(len, 1'($urandom_range(0, 1)), nb, ll);
      check("rand_nbursts", nb, (len + BS - 1) / BS);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
